// File: rtl/sensor_readout_ctrl_if.sv
// Output beat stream of the sensor readout stage.
// Source drives data and qualifiers; sink drives DATA_READY.
interface sensor_readout_ctrl_if #(
  parameter int DW = 8
);
  logic [DW-1:0] DATA_OUT;
  logic          DATA_VALID;
  logic          DATA_READY;
  logic          ROW_LAST;
  logic          FRAME_LAST;

  modport master (
    output DATA_OUT, DATA_VALID,
    output ROW_LAST, FRAME_LAST,
    input  DATA_READY
  );

  modport slave (
    input  DATA_OUT, DATA_VALID,
    input  ROW_LAST, FRAME_LAST,
    output DATA_READY
  );
endinterface

// File: rtl/sensor_readout_ctrl.sv
// Global-shutter sequencer plus ramp-ADC row conversion;
// each captured row is streamed as beats while the next converts.
module sensor_readout_ctrl #(
  parameter int HEIGHT       = 2,
  parameter int WIDTH        = 2,
  parameter int BUS_WIDTH    = 1,
  parameter int PIXEL_BITS   = 8,
  parameter int ERASE_CYCLES = 2,
  parameter int EXP_W        = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        START,
  input  logic                        MODE,
  input  logic [EXP_W-1:0]            EXPOSE_CYCLES,
  output logic                        PIXEL_ERASE,
  output logic                        PIXEL_EXPOSE,
  output logic [HEIGHT-1:0]           ROW_SELECT,
  output logic                        PIXEL_ANALOG_RAMP,
  output logic [PIXEL_BITS-1:0]       CONVERT_COUNTER,
  input  logic [WIDTH*PIXEL_BITS-1:0] ROW_DATA,
  sensor_readout_ctrl_if.master       out_if,
  output logic                        FRAME_FINISHED,
  output logic                        BUSY
);
  localparam int NB     = WIDTH / BUS_WIDTH;
  localparam int BEAT_W = BUS_WIDTH * PIXEL_BITS;
  localparam int BI_W   = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int EC_W   = $clog2(ERASE_CYCLES + 1);
  localparam int CW_A   = (EXP_W > PIXEL_BITS) ? EXP_W : PIXEL_BITS;
  localparam int CW     = (CW_A > EC_W) ? CW_A : EC_W;

  localparam logic [CW-1:0]   ERASE_LIM = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0]   CONV_LIM  = CW'({PIXEL_BITS{1'b1}});
  localparam logic [RW-1:0]   LAST_ROW  = RW'(HEIGHT - 1);
  localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_CAPTURE,
    S_WAIT
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [CW-1:0]               r_cnt;
  logic [EXP_W-1:0]            r_exp;
  logic                        r_mode;
  logic [RW-1:0]               r_row;
  logic [WIDTH*PIXEL_BITS-1:0] r_buf;
  logic [BI_W-1:0]             r_beat;
  logic                        r_buf_vld;
  logic                        r_buf_flast;
  logic                        r_done;

  logic w_latch;
  logic w_relatch;
  logic w_cap;
  logic w_acc;
  logic w_last_beat;
  logic w_row_done;
  logic w_buf_free;
  logic w_row_act;

  // Buffer counts as free when its last beat is accepted this cycle
  assign w_acc       = r_buf_vld & out_if.DATA_READY;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_row_done  = w_acc & w_last_beat;
  assign w_buf_free  = ~r_buf_vld | w_row_done;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_relatch = 1'b0;
    w_cap     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next  = S_ERASE;
          w_latch = 1'b1;
        end
      end
      S_ERASE: begin
        if (r_cnt == ERASE_LIM) w_next = S_EXPOSE;
      end
      S_EXPOSE: begin
        if (r_cnt == CW'(r_exp) - CW'(1)) w_next = S_CONVERT;
      end
      S_CONVERT: begin
        if (r_cnt == CONV_LIM) w_next = S_CAPTURE;
      end
      S_CAPTURE, S_WAIT: begin
        if (w_buf_free) begin
          w_cap = 1'b1;
          if (r_row != LAST_ROW) begin
            w_next = S_CONVERT;
          end else if (r_mode && START) begin
            w_next    = S_ERASE;
            w_relatch = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_next = S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt  <= '0;
      r_exp  <= '0;
      r_mode <= 1'b0;
      r_row  <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      if (w_latch) r_mode <= MODE;
      if (w_latch | w_relatch) begin
        r_exp <= (EXPOSE_CYCLES == '0) ? EXP_W'(1) : EXPOSE_CYCLES;
        r_row <= '0;
      end else if (w_cap && r_row != LAST_ROW) begin
        r_row <= r_row + RW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_buf       <= '0;
      r_beat      <= '0;
      r_buf_vld   <= 1'b0;
      r_buf_flast <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_row_done & r_buf_flast;
      if (w_cap) begin
        r_buf       <= ROW_DATA;
        r_beat      <= '0;
        r_buf_vld   <= 1'b1;
        r_buf_flast <= (r_row == LAST_ROW);
      end else if (w_row_done) begin
        r_buf_vld <= 1'b0;
      end else if (w_acc) begin
        r_beat <= r_beat + BI_W'(1);
      end
    end
  end

  assign w_row_act = (r_state == S_CONVERT) |
                     (r_state == S_CAPTURE) |
                     (r_state == S_WAIT);

  assign PIXEL_ERASE       = (r_state == S_ERASE);
  assign PIXEL_EXPOSE      = (r_state == S_EXPOSE);
  assign PIXEL_ANALOG_RAMP = (r_state == S_CONVERT);
  assign ROW_SELECT        = w_row_act ? (HEIGHT'(1) << r_row) : '0;
  assign CONVERT_COUNTER   = PIXEL_ANALOG_RAMP ?
                             r_cnt[PIXEL_BITS-1:0] : '0;

  assign out_if.DATA_OUT   = r_buf[int'(r_beat)*BEAT_W +: BEAT_W];
  assign out_if.DATA_VALID = r_buf_vld;
  assign out_if.ROW_LAST   = r_buf_vld & w_last_beat;
  assign out_if.FRAME_LAST = r_buf_vld & w_last_beat & r_buf_flast;

  assign FRAME_FINISHED = r_done;
  assign BUSY           = (r_state != S_IDLE) | r_buf_vld;
endmodule

// File: tb/tb_sensor_readout_ctrl.sv
// Randomized bench for sensor_readout_ctrl: a pixel-array model feeds
// rows; expected beats and strobe lengths come from the frame rules.
module tb_sensor_readout_ctrl;
  localparam int AH = 2, AW = 4, ABW = 2, APB = 4, AE = 2;
  localparam int ANB = AW / ABW, ABEAT = ABW * APB, AROW = AW * APB;
  localparam int BH = 3, BW = 8, BBW = 4, BPB = 8;
  localparam int BNB = BW / BBW, BBEAT = BBW * BPB, BROW = BW * BPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: default bench parameters
  logic            a_start, a_mode;
  logic [7:0]      a_exp;
  logic            a_erase, a_expose, a_ramp, a_ff, a_busy;
  logic [AH-1:0]   a_rs;
  logic [APB-1:0]  a_cc;
  logic [AROW-1:0] a_rd;
  logic [AROW-1:0] a_mem [AH];
  logic            a_ready, a_rdy_fix, a_rand_rdy;
  logic [63:0]     a_q [$];
  int              a_exp_len, a_ff_cnt;

  sensor_readout_ctrl_if #(.DW(ABEAT)) a_if ();
  assign a_if.DATA_READY = a_ready;

  sensor_readout_ctrl #(
    .HEIGHT(AH), .WIDTH(AW), .BUS_WIDTH(ABW), .PIXEL_BITS(APB),
    .ERASE_CYCLES(AE), .EXP_W(8)
  ) u_a (
    .CLK(clk), .RESET(rst_n), .START(a_start), .MODE(a_mode),
    .EXPOSE_CYCLES(a_exp), .PIXEL_ERASE(a_erase),
    .PIXEL_EXPOSE(a_expose), .ROW_SELECT(a_rs),
    .PIXEL_ANALOG_RAMP(a_ramp), .CONVERT_COUNTER(a_cc),
    .ROW_DATA(a_rd), .out_if(a_if.master),
    .FRAME_FINISHED(a_ff), .BUSY(a_busy)
  );

  always_comb begin
    a_rd = '0;
    for (int r = 0; r < AH; r++)
      if (a_rs == (AH'(1) << r)) a_rd = a_mem[r];
  end

  always @(posedge clk) begin
    #2;
    a_ready = a_rand_rdy ? 1'($urandom_range(0, 1)) : a_rdy_fix;
  end

  logic [21:0] a_outs;
  assign a_outs = {a_erase, a_expose, a_rs, a_ramp, a_cc,
                   a_if.DATA_OUT, a_if.DATA_VALID, a_if.ROW_LAST,
                   a_if.FRAME_LAST, a_ff, a_busy};

  int a_er_len = 0, a_ex_len = 0, a_rp_len = 0;
  logic a_rp_bad = 1'b0;

  always @(negedge clk) begin
    logic [63:0] obs, ex;
    if (!rst_n) begin
      a_er_len = 0; a_ex_len = 0; a_rp_len = 0; a_rp_bad = 1'b0;
    end else begin
      if (a_if.DATA_VALID && a_if.DATA_READY) begin
        obs = '0;
        obs[ABEAT-1:0] = a_if.DATA_OUT;
        obs[32] = a_if.FRAME_LAST;
        obs[33] = a_if.ROW_LAST;
        ex = (a_q.size() > 0) ? a_q.pop_front() : '1;
        chk("a_beat", obs, ex);
      end
      if (a_ff) a_ff_cnt++;
      if (a_erase) a_er_len++;
      else if (a_er_len > 0) begin
        chk("a_erase_len", a_er_len, AE);
        a_er_len = 0;
      end
      if (a_expose) a_ex_len++;
      else if (a_ex_len > 0) begin
        chk("a_expose_len", a_ex_len, a_exp_len);
        a_ex_len = 0;
      end
      if (a_ramp) begin
        if (a_cc != APB'(a_rp_len)) a_rp_bad = 1'b1;
        a_rp_len++;
      end else if (a_rp_len > 0) begin
        chk("a_ramp_len", a_rp_len, 1 << APB);
        chk("a_ramp_seq", a_rp_bad, 0);
        a_rp_len = 0;
        a_rp_bad = 1'b0;
      end
    end
  end

  task automatic a_push();
    logic [63:0] e;
    for (int r = 0; r < AH; r++)
      for (int k = 0; k < ANB; k++) begin
        e = '0;
        e[ABEAT-1:0] = a_mem[r][k*ABEAT +: ABEAT];
        e[33] = (k == ANB - 1);
        e[32] = (k == ANB - 1) && (r == AH - 1);
        a_q.push_back(e);
      end
  endtask

  task automatic a_go(input logic md, input logic [7:0] e);
    a_mode = md;
    a_exp = e;
    a_exp_len = (e == 0) ? 1 : int'(e);
    a_start = 1'b1;
    @(posedge clk); #1;
    if (!md) a_start = 1'b0;
  endtask

  task automatic a_wait_rs(input logic [AH-1:0] rs, input logic rmp,
                           input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_rs == rs && a_ramp == rmp) && n < 1000);
    chk(tag, {a_rs, a_ramp}, {rs, rmp});
  endtask

  task automatic a_wait_idle(input int budget, input string tag);
    int n = 0;
    while (a_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, a_busy, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- DUT B: parameter sweep
  logic            b_start, b_mode;
  logic [7:0]      b_exp;
  logic            b_erase, b_expose, b_ramp, b_ff, b_busy;
  logic [BH-1:0]   b_rs;
  logic [BPB-1:0]  b_cc;
  logic [BROW-1:0] b_rd;
  logic [BROW-1:0] b_mem [BH];
  logic [63:0]     b_q [$];
  int              b_ff_cnt;

  sensor_readout_ctrl_if #(.DW(BBEAT)) b_if ();
  assign b_if.DATA_READY = 1'b1;

  sensor_readout_ctrl #(
    .HEIGHT(BH), .WIDTH(BW), .BUS_WIDTH(BBW), .PIXEL_BITS(BPB),
    .ERASE_CYCLES(2), .EXP_W(8)
  ) u_b (
    .CLK(clk), .RESET(rst_n), .START(b_start), .MODE(b_mode),
    .EXPOSE_CYCLES(b_exp), .PIXEL_ERASE(b_erase),
    .PIXEL_EXPOSE(b_expose), .ROW_SELECT(b_rs),
    .PIXEL_ANALOG_RAMP(b_ramp), .CONVERT_COUNTER(b_cc),
    .ROW_DATA(b_rd), .out_if(b_if.master),
    .FRAME_FINISHED(b_ff), .BUSY(b_busy)
  );

  always_comb begin
    b_rd = '0;
    for (int r = 0; r < BH; r++)
      if (b_rs == (BH'(1) << r)) b_rd = b_mem[r];
  end

  logic [50:0] b_outs;
  assign b_outs = {b_erase, b_expose, b_rs, b_ramp, b_cc,
                   b_if.DATA_OUT, b_if.DATA_VALID, b_if.ROW_LAST,
                   b_if.FRAME_LAST, b_ff, b_busy};

  int b_rp_len = 0;
  logic b_rp_bad = 1'b0;

  always @(negedge clk) begin
    logic [63:0] obs, ex;
    if (!rst_n) begin
      b_rp_len = 0; b_rp_bad = 1'b0;
    end else begin
      if (b_if.DATA_VALID && b_if.DATA_READY) begin
        obs = '0;
        obs[BBEAT-1:0] = b_if.DATA_OUT;
        obs[32] = b_if.FRAME_LAST;
        obs[33] = b_if.ROW_LAST;
        ex = (b_q.size() > 0) ? b_q.pop_front() : '1;
        chk("b_beat", obs, ex);
      end
      if (b_ff) b_ff_cnt++;
      if (b_ramp) begin
        if (b_cc != BPB'(b_rp_len)) b_rp_bad = 1'b1;
        b_rp_len++;
      end else if (b_rp_len > 0) begin
        chk("b_ramp_len", b_rp_len, 1 << BPB);
        chk("b_ramp_seq", b_rp_bad, 0);
        b_rp_len = 0;
        b_rp_bad = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ff0;
    logic [63:0] e;
    rst_n = 1'b0;
    a_start = 0; a_mode = 0; a_exp = 0;
    a_rdy_fix = 0; a_rand_rdy = 0; a_ready = 0;
    b_start = 0; b_mode = 0; b_exp = 0;
    a_ff_cnt = 0; b_ff_cnt = 0; a_exp_len = 1;
    for (int r = 0; r < AH; r++) a_mem[r] = '0;
    for (int r = 0; r < BH; r++) b_mem[r] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_reset_outs", a_outs, 0);
    chk("b_reset_outs", b_outs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // single frame with fixed pixel data
    a_mem[0] = 16'h4321; a_mem[1] = 16'h8765;
    a_rdy_fix = 1'b1;
    a_push();
    ff0 = a_ff_cnt;
    @(negedge clk);
    chk("a_erase_pre", a_erase, 0);
    @(posedge clk); #1;
    a_go(1'b0, 8'd3);
    @(negedge clk);
    chk("a_erase_rise", a_erase, 1);
    @(posedge clk); #1;
    a_wait_idle(500, "a_single_idle");
    chk("a_single_ff", a_ff_cnt - ff0, 1);
    chk("a_single_q", a_q.size(), 0);

    // backpressure through row 1 conversion
    a_rdy_fix = 1'b0;
    @(posedge clk); #1;
    a_push();
    ff0 = a_ff_cnt;
    a_go(1'b0, 8'd2);
    a_wait_rs(2'b10, 1'b0, "a_bp_reach");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("a_bp_rowsel", a_rs, 2'b10);
      chk("a_bp_dout", {a_if.DATA_VALID, a_if.DATA_OUT}, {1'b1, 8'h21});
    end
    @(posedge clk); #1;
    a_rdy_fix = 1'b1;
    a_wait_idle(500, "a_bp_idle");
    chk("a_bp_ff", a_ff_cnt - ff0, 1);
    chk("a_bp_q", a_q.size(), 0);

    // zero exposure is stretched to one cycle
    for (int r = 0; r < AH; r++) a_mem[r] = AROW'($urandom);
    a_push();
    a_go(1'b0, 8'd0);
    a_wait_idle(500, "a_zero_idle");
    chk("a_zero_q", a_q.size(), 0);

    // continuous mode, two frames
    for (int r = 0; r < AH; r++) a_mem[r] = AROW'($urandom);
    a_push();
    a_push();
    ff0 = a_ff_cnt;
    a_go(1'b1, 8'd4);
    a_wait_rs(2'b10, 1'b0, "a_cont_cap");
    @(negedge clk);
    chk("a_cont_erase", a_erase, 1);
    @(posedge clk); #1;
    a_start = 1'b0;
    a_wait_idle(1000, "a_cont_idle");
    chk("a_cont_ff", a_ff_cnt - ff0, 2);
    chk("a_cont_q", a_q.size(), 0);

    // reset while row 1 converts and row 0 is buffered
    a_rdy_fix = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < AH; r++) a_mem[r] = AROW'($urandom);
    a_go(1'b0, 8'($urandom_range(1, 5)));
    a_wait_rs(2'b10, 1'b1, "a_rst_reach");
    repeat (3) @(negedge clk);
    chk("a_rst_pre_valid", a_if.DATA_VALID, 1);
    rst_n = 1'b0;
    #1;
    chk("a_rst_outs", a_outs, 0);
    a_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ff0 = a_ff_cnt;
    a_rdy_fix = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("a_rst_noff", a_ff_cnt - ff0, 0);
    chk("a_rst_busy", a_busy, 0);
    for (int r = 0; r < AH; r++) a_mem[r] = AROW'($urandom);
    a_push();
    a_go(1'b0, 8'($urandom_range(0, 5)));
    a_wait_idle(500, "a_rst_idle");
    chk("a_rst_ff", a_ff_cnt - ff0, 1);
    chk("a_rst_q", a_q.size(), 0);

    // random frames with random backpressure
    a_rand_rdy = 1'b1;
    ff0 = a_ff_cnt;
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < AH; r++) a_mem[r] = AROW'($urandom);
      a_push();
      a_go(1'b0, 8'($urandom_range(0, 5)));
      a_wait_idle(3000, "a_rand_idle");
      chk("a_rand_q", a_q.size(), 0);
    end
    a_rand_rdy = 1'b0;
    chk("a_rand_ff", a_ff_cnt - ff0, 6);

    // wide configuration
    for (int r = 0; r < BH; r++) b_mem[r] = {$urandom, $urandom};
    for (int r = 0; r < BH; r++)
      for (int k = 0; k < BNB; k++) begin
        e = '0;
        e[BBEAT-1:0] = b_mem[r][k*BBEAT +: BBEAT];
        e[33] = (k == BNB - 1);
        e[32] = (k == BNB - 1) && (r == BH - 1);
        b_q.push_back(e);
      end
    b_exp = 8'($urandom_range(0, 6));
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    begin
      int n = 0;
      while (b_busy && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("b_idle", b_busy, 0);
    end
    @(posedge clk); #1;
    chk("b_ff", b_ff_cnt, 1);
    chk("b_q", b_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
